// File: rtl/display_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_ctrl
// Brief    : Frame-arbitrated scan scheduler for a 5-position clock display
//            (digits at 4,3,1,0 and colon at 2). Optional build macro:
//            LEADING_ZERO_BLANK_EN blanks a zero leading digit at position 4.
// Revision : 1.0 - initial release
// ============================================================================
module display_scan_ctrl #(
  parameter int DWELL_CYC = 4,
  parameter int BLANK_CYC = 1
) (
  input  logic        clk_1ms,
  input  logic        reset_n,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic        colon_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  input  logic        colon_b,
  output logic        grant_a,
  output logic        grant_b,
  output logic [2:0]  digit_select,
  output logic        digit_en,
  output logic [3:0]  bcd_out,
  output logic        colon_on,
  output logic        frame_done
);

  typedef enum logic [1:0] {
    S_ARB   = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  localparam int c_CNT_MAX = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int c_CNT_W   = $clog2(c_CNT_MAX) + 1;
  localparam logic [c_CNT_W-1:0] c_DWELL_LAST = c_CNT_W'(DWELL_CYC - 1);
  localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam state_t c_POS_ENTRY = (BLANK_CYC > 0) ? S_BLANK : S_SHOW;

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_pos, w_pos_nxt;
  logic [c_CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [15:0]          r_snap, w_snap_nxt;
  logic                 r_colon_snap, w_colon_snap_nxt;
  logic                 w_grant_a_nxt, w_grant_b_nxt;
  logic                 w_frame_done_nxt;
  logic                 w_digit_en_nxt;
  logic [3:0]           w_bcd_nxt;
  logic                 w_colon_on_nxt;
  logic                 w_owner_nxt;

  // Position 2 carries the colon, so it has no digit nibble.
  function automatic logic [3:0] pick_digit(input logic [15:0] d, input logic [2:0] p);
    logic [3:0] v;
    v = 4'h0;
    case (p)
      3'd4:    v = d[15:12];
      3'd3:    v = d[11:8];
      3'd1:    v = d[7:4];
      3'd0:    v = d[3:0];
      default: v = 4'h0;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk_1ms or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_ARB;
      r_pos        <= 3'd4;
      r_cnt        <= '0;
      r_snap       <= '0;
      r_colon_snap <= 1'b0;
      grant_a      <= 1'b0;
      grant_b      <= 1'b0;
      digit_select <= 3'd4;
      digit_en     <= 1'b0;
      bcd_out      <= 4'h0;
      colon_on     <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pos        <= w_pos_nxt;
      r_cnt        <= w_cnt_nxt;
      r_snap       <= w_snap_nxt;
      r_colon_snap <= w_colon_snap_nxt;
      grant_a      <= w_grant_a_nxt;
      grant_b      <= w_grant_b_nxt;
      digit_select <= w_pos_nxt;
      digit_en     <= w_digit_en_nxt;
      bcd_out      <= w_bcd_nxt;
      colon_on     <= w_colon_on_nxt;
      frame_done   <= w_frame_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_pos_nxt        = r_pos;
    w_cnt_nxt        = r_cnt;
    w_snap_nxt       = r_snap;
    w_colon_snap_nxt = r_colon_snap;
    w_grant_a_nxt    = grant_a;
    w_grant_b_nxt    = grant_b;
    w_frame_done_nxt = 1'b0;

    case (r_state)
      S_ARB: begin
        // B has strict priority; A may starve while B keeps requesting.
        w_state_nxt      = c_POS_ENTRY;
        w_pos_nxt        = 3'd4;
        w_cnt_nxt        = '0;
        w_grant_b_nxt    = req_b;
        w_grant_a_nxt    = req_a & ~req_b;
        w_snap_nxt       = req_b ? data_b  : (req_a ? data_a  : 16'h0000);
        w_colon_snap_nxt = req_b ? colon_b : (req_a ? colon_a : 1'b0);
      end
      S_BLANK: begin
        if (r_cnt == c_BLANK_LAST) begin
          w_state_nxt = S_SHOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_SHOW: begin
        if (r_cnt == c_DWELL_LAST) begin
          w_cnt_nxt = '0;
          if (r_pos == 3'd0) begin
            w_state_nxt      = S_ARB;
            w_frame_done_nxt = 1'b1;
          end else begin
            w_pos_nxt   = r_pos - 3'd1;
            w_state_nxt = c_POS_ENTRY;
          end
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_ARB;
      end
    endcase

    // Output registers are loaded from next-state values so they line up with the state.
    w_owner_nxt    = w_grant_a_nxt | w_grant_b_nxt;
    w_digit_en_nxt = 1'b0;
    w_bcd_nxt      = 4'h0;
    w_colon_on_nxt = 1'b0;
    if (w_state_nxt == S_SHOW) begin
      w_bcd_nxt      = pick_digit(w_snap_nxt, w_pos_nxt);
      w_digit_en_nxt = w_owner_nxt;
      w_colon_on_nxt = w_owner_nxt & w_colon_snap_nxt & (w_pos_nxt == 3'd2);
`ifdef LEADING_ZERO_BLANK_EN
      if ((w_pos_nxt == 3'd4) && (w_snap_nxt[15:12] == 4'h0)) begin
        w_digit_en_nxt = 1'b0;
      end
`else
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_display_scan_ctrl.sv
`default_nettype none
// Testbench for display_scan_ctrl: randomized stimulus against a frame-level reference model.
module tb_display_scan_ctrl;

  localparam int DWELL = 4;
  localparam int BLANK = 1;
  localparam int SLOT  = BLANK + DWELL;
  localparam int FRAME = 1 + 5 * SLOT;

  logic        clk_1ms = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0, colon_a = 1'b0, colon_b = 1'b0;
  logic [15:0] data_a = '0, data_b = '0;
  logic        grant_a, grant_b, digit_en, colon_on, frame_done;
  logic [2:0]  digit_select;
  logic [3:0]  bcd_out;
  logic [11:0] obs;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: frame offset (0 = arbitration cycle) and the frame owner's snapshot.
  int          m_t = 0;
  logic        m_ga = 1'b0, m_gb = 1'b0, m_colon = 1'b0;
  logic [15:0] m_data = '0;

  display_scan_ctrl #(.DWELL_CYC(DWELL), .BLANK_CYC(BLANK)) dut (
    .clk_1ms(clk_1ms), .reset_n(reset_n),
    .req_a(req_a), .data_a(data_a), .colon_a(colon_a),
    .req_b(req_b), .data_b(data_b), .colon_b(colon_b),
    .grant_a(grant_a), .grant_b(grant_b), .digit_select(digit_select),
    .digit_en(digit_en), .bcd_out(bcd_out), .colon_on(colon_on), .frame_done(frame_done)
  );

  assign obs = {grant_a, grant_b, digit_select, digit_en, bcd_out, colon_on, frame_done};

  always #5 clk_1ms = ~clk_1ms;

  task automatic model_reset();
    m_t = 0; m_ga = 1'b0; m_gb = 1'b0; m_colon = 1'b0; m_data = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk_1ms);
    @(posedge clk_1ms);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  // One clock; the model arbitrates on the edge that ends the arbitration cycle.
  task automatic tick();
    @(posedge clk_1ms);
    if (m_t == 0) begin
      m_gb = req_b;
      m_ga = req_a && !req_b;
      m_data  = req_b ? data_b  : (req_a ? data_a  : 16'h0);
      m_colon = req_b ? colon_b : (req_a ? colon_a : 1'b0);
    end
    m_t = (m_t + 1) % FRAME;
    #1;
  endtask

  // Expected {grant_a,grant_b,sel[2:0],en,bcd[3:0],colon,frame_done} and a care mask.
  task automatic model_expect(output logic [11:0] e, output logic [11:0] m);
    int k, ph, p, idx;
    logic [3:0] nib;
    logic own;
    own = m_ga | m_gb;
    e = '0;
    if (m_t == 0) begin
      e[0] = 1'b1;
      m = 12'h07F;
    end else begin
      k   = (m_t - 1) / SLOT;
      ph  = (m_t - 1) % SLOT;
      p   = 4 - k;
      idx = (p > 2) ? p - 1 : p;
      nib = 4'((m_data >> (4 * idx)) & 16'hF);
      e[11]  = m_ga;
      e[10]  = m_gb;
      e[9:7] = 3'(p);
      if (ph < BLANK) begin
        m = 12'hFC3;
      end else begin
        m = own ? 12'hFFF : 12'hFC3;
        e[5:2] = (p == 2) ? 4'h0 : nib;
        e[6]   = own;
`ifdef LEADING_ZERO_BLANK_EN
        if (p == 4 && nib == 4'h0) e[6] = 1'b0;
`endif
        e[1] = own && (p == 2) && m_colon;
      end
    end
  endtask

  task automatic test_reset();
    req_a = 1'b1; req_b = 1'b1; data_a = 16'(($urandom)); data_b = 16'(($urandom));
    colon_a = 1'b1; colon_b = 1'b1;
    do_reset();
    tests_run++; if (grant_a !== 1'b0) begin tests_failed++; $display("FAIL reset_grant_a got=%b exp=0", grant_a); end
    tests_run++; if (grant_b !== 1'b0) begin tests_failed++; $display("FAIL reset_grant_b got=%b exp=0", grant_b); end
    tests_run++; if (digit_select !== 3'd4) begin tests_failed++; $display("FAIL reset_digit_select got=%0d exp=4", digit_select); end
    tests_run++; if (digit_en !== 1'b0) begin tests_failed++; $display("FAIL reset_digit_en got=%b exp=0", digit_en); end
    tests_run++; if (bcd_out !== 4'h0) begin tests_failed++; $display("FAIL reset_bcd_out got=%h exp=0", bcd_out); end
    tests_run++; if (colon_on !== 1'b0) begin tests_failed++; $display("FAIL reset_colon_on got=%b exp=0", colon_on); end
    tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
  endtask

  task automatic test_single_a();
    logic [11:0] e, m;
    int first_done = -1;
    req_a = 1'b1; req_b = 1'b0; data_a = 16'h1234; colon_a = 1'b1;
    do_reset();
    for (int c = 1; c <= 2 * FRAME; c++) begin
      tick();
      if (frame_done === 1'b1 && first_done < 0) first_done = c;
      model_expect(e, m);
      tests_run++;
      if ((obs & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL single_a cyc=%0d got=%h exp=%h mask=%h", c, obs, e, m);
      end
    end
    tests_run++;
    if (first_done != FRAME) begin
      tests_failed++;
      $display("FAIL first_frame_done got=%0d exp=%0d", first_done, FRAME);
    end
  endtask

  task automatic test_both_b_wins();
    logic [11:0] e, m;
    req_a = 1'b1; req_b = 1'b1; data_b = 16'h0930; colon_b = 1'($urandom);
    data_a = 16'($urandom); colon_a = 1'b1;
    do_reset();
    for (int c = 1; c <= 2 * FRAME; c++) begin
      tick();
      model_expect(e, m);
      tests_run++;
      if ((obs & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL both_b_wins cyc=%0d got=%h exp=%h mask=%h", c, obs, e, m);
      end
    end
  endtask

  task automatic test_handover();
    logic [11:0] e, m;
    req_a = 1'b1; req_b = 1'b1; data_a = 16'($urandom); data_b = 16'($urandom);
    colon_a = 1'($urandom); colon_b = 1'($urandom);
    do_reset();
    for (int c = 1; c <= 2 * FRAME + 5; c++) begin
      tick();
      model_expect(e, m);
      tests_run++;
      if ((obs & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL handover cyc=%0d got=%h exp=%h mask=%h", c, obs, e, m);
      end
      if (c == 10) req_b = 1'b0;
    end
  endtask

  task automatic test_data_change();
    logic [11:0] e, m;
    req_a = 1'b1; req_b = 1'b0; data_a = 16'h1234; colon_a = 1'b1;
    do_reset();
    for (int c = 1; c <= 2 * FRAME + 3; c++) begin
      tick();
      model_expect(e, m);
      tests_run++;
      if ((obs & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL data_change cyc=%0d got=%h exp=%h mask=%h", c, obs, e, m);
      end
      if (c == 12) begin data_a = 16'h5678; colon_a = 1'b0; end
    end
  endtask

  task automatic test_idle();
    logic [11:0] e, m;
    req_a = 1'b0; req_b = 1'b0; data_a = 16'($urandom); data_b = 16'($urandom);
    colon_a = 1'b1; colon_b = 1'b1;
    do_reset();
    for (int c = 1; c <= 2 * FRAME; c++) begin
      tick();
      model_expect(e, m);
      tests_run++;
      if ((obs & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL idle cyc=%0d got=%h exp=%h mask=%h", c, obs, e, m);
      end
    end
  endtask

  task automatic test_random();
    logic [11:0] e, m;
    do_reset();
    for (int c = 1; c <= 8 * FRAME; c++) begin
      req_a   = ($urandom_range(0, 3) != 0);
      req_b   = ($urandom_range(0, 2) == 0);
      data_a  = 16'($urandom);
      data_b  = ($urandom_range(0, 1) == 0) ? 16'($urandom) & 16'h0FFF : 16'($urandom);
      colon_a = 1'($urandom);
      colon_b = 1'($urandom);
      tick();
      model_expect(e, m);
      tests_run++;
      if ((obs & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL random cyc=%0d got=%h exp=%h mask=%h", c, obs, e, m);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [11:0] e, m;
    req_a = 1'b1; req_b = 1'b0; data_a = 16'h1234; colon_a = 1'b1;
    do_reset();
    while (m_t != 18) tick();
    tests_run++;
    if (digit_en !== 1'b1 || digit_select !== 3'd1) begin
      tests_failed++;
      $display("FAIL pre_async_pos1 got_en=%b got_sel=%0d exp_en=1 exp_sel=1", digit_en, digit_select);
    end
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (obs !== 12'b0_0_100_0_0000_0_0) begin
      tests_failed++;
      $display("FAIL async_reset got=%h exp=%h", obs, 12'b0_0_100_0_0000_0_0);
    end
    @(posedge clk_1ms);
    #1 reset_n = 1'b1;
    model_reset();
    data_b = 16'h0930; req_b = 1'b1;
    for (int c = 1; c <= FRAME + 2; c++) begin
      tick();
      model_expect(e, m);
      tests_run++;
      if ((obs & m) !== (e & m)) begin
        tests_failed++;
        $display("FAIL after_async cyc=%0d got=%h exp=%h mask=%h", c, obs, e, m);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_a();
    test_both_b_wins();
    test_handover();
    test_data_change();
    test_idle();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
